// File: rtl/onehot_encoder_stream.sv
// onehot_encoder_stream: one-hot to binary encoder with validity flag, 2-entry output FIFO and saturating error count
module onehot_encoder_stream #(
  parameter  int NUM_INPUT = 4,
  parameter  int ERR_CNT_W = 8,
  localparam int ADDR_W    = $clog2(NUM_INPUT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_INPUT-1:0] in_select,
  input  logic                 in_clear_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_address,
  output logic                 out_error,
  output logic [ERR_CNT_W-1:0] out_err_count
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      enc_addr, head_addr, tail_addr;
  logic                   enc_err, head_err, tail_err;
  logic                   accept, take, load_head, load_tail, shift;
  logic [ERR_CNT_W-1:0]   err_cnt, cnt_base, cnt_nxt;
  assign in_ready      = (state != FULL) && !rst;
  assign out_valid     = state != EMPTY;
  assign accept        = in_valid && in_ready;
  assign take          = out_valid && out_ready;
  assign out_address   = head_addr;
  assign out_error     = head_err;
  assign out_err_count = err_cnt;
  // lowest set bit wins; anything but exactly one bit set is an error
  always_comb begin
    enc_addr = '0;
    for (int i = NUM_INPUT - 1; i >= 0; i--)
      if (in_select[i]) enc_addr = ADDR_W'(i);
    enc_err = (in_select == '0) || ((in_select & (in_select - NUM_INPUT'(1))) != '0);
  end
  // buffer occupancy transitions and which register each handshake updates
  always_comb begin
    state_nxt = (state == EMPTY) ? (accept ? ONE : EMPTY) :
                (state == ONE)   ? ((accept && !take) ? FULL : (take && !accept) ? EMPTY : ONE) :
                                   (take ? ONE : FULL);
    load_head = accept && ((state == EMPTY) || (state == ONE && take));
    load_tail = accept && state == ONE && !take;
    shift     = take && state == FULL;
  end
  // clear takes effect first so a same-cycle erroneous accept still counts
  always_comb begin
    cnt_base = in_clear_count ? '0 : err_cnt;
    cnt_nxt  = (accept && enc_err && cnt_base != '1) ? cnt_base + 1'b1 : cnt_base;
  end
  // occupancy state and error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      err_cnt <= cnt_nxt;
    end
  end
  // head drives the outputs; tail only holds the second word while FULL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_addr <= '0;
      head_err  <= 1'b0;
      tail_addr <= '0;
      tail_err  <= 1'b0;
    end else begin
      if (load_head) begin
        head_addr <= enc_addr;
        head_err  <= enc_err;
      end else if (shift) begin
        head_addr <= tail_addr;
        head_err  <= tail_err;
      end
      if (load_tail) begin
        tail_addr <= enc_addr;
        tail_err  <= enc_err;
      end
    end
  end
endmodule

// File: tb/tb_onehot_encoder_stream.sv
// tb_onehot_encoder_stream: scoreboard bench for onehot_encoder_stream
module tb_onehot_encoder_stream;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_clear_count, out_ready;
  logic [3:0] in_select;
  logic       in_ready, out_valid, out_error;
  logic [1:0] out_address;
  logic [7:0] out_err_count;
  logic       sat_in_ready, sat_out_valid, sat_out_error;
  logic [1:0] sat_out_address, sat_err_count;
  logic [2:0] sb[$];
  int         n_cmp = 0, n_bad = 0;
  int         w;

  always #5 clk = ~clk;

  onehot_encoder_stream u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_select(in_select), .in_clear_count(in_clear_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_address(out_address),
    .out_error(out_error), .out_err_count(out_err_count)
  );

  onehot_encoder_stream #(.ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_select(in_select), .in_clear_count(in_clear_count),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_address(sat_out_address),
    .out_error(sat_out_error), .out_err_count(sat_err_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [3:0] sel, input logic [1:0] a, input logic e, output int waits);
    in_select = sel;
    in_valid  = 1'b1;
    waits     = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
    end
    if (in_ready) sb.push_back({a, e});
    else chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        logic [2:0] exp;
        exp = sb.pop_front();
        chk("out_payload", int'({out_address, out_error}), int'(exp));
        chk("sat_payload", int'({sat_out_address, sat_out_error}), int'(exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_select = '0; in_clear_count = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", out_err_count, 0);
    chk("rst_address", out_address, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    // reset while full discards everything at once
    send(4'b0000, 2'd0, 1'b1, w);
    send(4'b0010, 2'd1, 1'b0, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_count", out_err_count, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 0);
    chk("async_count", out_err_count, 0);
    chk("async_error", out_error, 0);
    sb.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    // full-rate stream of valid codes
    out_ready = 1'b1;
    send(4'b0001, 2'd0, 1'b0, w);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_address", out_address, 0);
    chk("lat_error", out_error, 0);
    send(4'b0010, 2'd1, 1'b0, w); chk("stream_wait1", w, 0);
    send(4'b0100, 2'd2, 1'b0, w); chk("stream_wait2", w, 0);
    send(4'b1000, 2'd3, 1'b0, w); chk("stream_wait3", w, 0);
    idle(3);
    // invalid codes
    send(4'b0000, 2'd0, 1'b1, w);
    send(4'b0110, 2'd1, 1'b1, w);
    idle(3);
    chk("err_count2", out_err_count, 2);
    chk("sat_count2", sat_err_count, 2);
    // back-pressure: third word must wait for a take
    out_ready = 1'b0;
    send(4'b0010, 2'd1, 1'b0, w);
    send(4'b0100, 2'd2, 1'b0, w);
    in_select = 4'b1000;
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head", out_address, 1);
    @(posedge clk); #1;
    chk("bp_stable", out_address, 1);
    out_ready = 1'b1;
    send(4'b1000, 2'd3, 1'b0, w);
    chk("bp_waited", int'(w > 0), 1);
    idle(4);
    chk("bp_empty", out_valid, 0);
    // accept and take together in ONE
    out_ready = 1'b0;
    send(4'b0001, 2'd0, 1'b0, w);
    out_ready = 1'b1;
    send(4'b0100, 2'd2, 1'b0, w);
    chk("one_out_valid", out_valid, 1);
    chk("one_in_ready", in_ready, 1);
    chk("one_address", out_address, 2);
    send(4'b1000, 2'd3, 1'b0, w);
    chk("one_address2", out_address, 3);
    idle(3);
    // saturation and clear-then-count
    in_clear_count = 1'b1;
    @(posedge clk); #1;
    in_clear_count = 1'b0;
    chk("clr_count", out_err_count, 0);
    chk("clr_sat", sat_err_count, 0);
    send(4'b0011, 2'd0, 1'b1, w);
    send(4'b1100, 2'd2, 1'b1, w);
    send(4'b0000, 2'd0, 1'b1, w);
    send(4'b1111, 2'd0, 1'b1, w);
    send(4'b1010, 2'd1, 1'b1, w);
    idle(3);
    chk("cnt5", out_err_count, 5);
    chk("sat3", sat_err_count, 3);
    in_clear_count = 1'b1;
    send(4'b0011, 2'd0, 1'b1, w);
    in_clear_count = 1'b0;
    idle(3);
    chk("clr_cnt1", out_err_count, 1);
    chk("clr_sat1", sat_err_count, 1);
    idle(5);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
